axi4_burst_master: RTL and testbench
====================================

Name: axi4_burst_master

Overview:
- AXI4 memory-mapped initiator. Converts single-entry read/write burst commands from a local client into AXI4 AW/W/B or AR/R channel traffic toward the memory-mapped slave.
- One transaction in flight at a time. INCR bursts only, 32-bit beats.
- Write data is streamed in from the client; read data is streamed out to it.
- Ends each command with a one-cycle completion pulse carrying the response.

Parameters:
ADDR_W, 16, byte address width on AWADDR/ARADDR/cmd_addr
DATA_W, 32, beat width; fixed 32 (AWSIZE/ARSIZE = 3'b010)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  start byte address; [1:0] ignored (forced 0)
cmd_len  in  8  beats-1 (AXI LEN encoding)
wr_data  in  DATA_W  write beat from client
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat consumed when wr_valid&&wr_ready
rd_data  out  DATA_W  read beat to client
rd_valid  out  1  read beat valid
rd_ready  in  1  client accepts read beat (drives RREADY)
done  out  1  one-cycle completion pulse
done_resp  out  2  worst response of burst; valid with done
done_err  out  1  with done: boundary reject or RLAST mismatch
AWADDR/AWLEN/AWSIZE/AWVALID  out  ADDR_W/8/3/1  write address channel
AWREADY  in  1
WDATA/WLAST/WVALID  out  32/1/1  write data channel
WREADY  in  1
BRESP/BVALID  in  2/1 ; BREADY out 1  write response channel
ARADDR/ARLEN/ARSIZE/ARVALID  out  ADDR_W/8/3/1  read address channel
ARREADY  in  1
RDATA/RRESP/RLAST/RVALID  in  32/2/1/1 ; RREADY out 1  read data channel

Behaviour:
- Reset (async assert, sync release): state IDLE; all VALIDs, BREADY, RREADY, cmd_ready, wr_ready, rd_valid, done, done_err = 0; done_resp = 0; address/len registers = 0.
  - Reset mid-burst abandons the burst. No further beats or completion are issued.
- FSM states: IDLE, CHECK, AW, W, B, AR, R, DONE.
- IDLE: cmd_ready=1. On accept, latch cmd_write, {cmd_addr[ADDR_W-1:2],2'b00}, cmd_len; go to CHECK. cmd_ready=0 in every other state.
- CHECK (one cycle): compute end = addr[11:0] + (len+1)*4 in 13 bits.
  - end > 4096: go to DONE with done_err=1, done_resp=2'b10; no AXI traffic.
  - Otherwise go to AW (write) or AR (read).
- AW: AWVALID=1 with AWADDR, AWLEN=len, AWSIZE=3'b010. These signals hold stable until AWREADY; then go to W. Once asserted, AWVALID never drops without the handshake.
- W: beat counter starts at 0.
  - WVALID = wr_valid; WDATA = wr_data; wr_ready = WREADY (combinational pass-through).
  - WLAST = (beat==len).
  - On WVALID&&WREADY, increment the beat counter; on the last beat, go to B.
  - No data is written before the AW handshake.
- B: BREADY=1. On BVALID, done_resp=BRESP; go to DONE.
- AR: ARVALID/ARADDR/ARLEN/ARSIZE with the same stability rules as AW; on ARREADY go to R.
- R: RREADY = rd_ready; rd_valid = RVALID; rd_data = RDATA (pass-through).
  - On each handshake: resp accumulator = max(acc, RRESP), compared numerically; beat counter increments.
  - RLAST asserted on a beat other than beat==len, or absent on beat==len: latch done_err=1.
  - Transaction completes on the beat==len handshake.
- DONE: done=1 for exactly one cycle with done_resp/done_err; then back to IDLE with done_err and accumulator cleared.
- Latency: command accept to AWVALID/ARVALID = 2 cycles.
- Counters are 9 bits internally so len=255 (256 beats) does not wrap early.
- len=0 is a single beat with WLAST=1 on that beat.

Decomposition:
- Package axi4_pkg: resp encodings (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), SIZE_4B=3'b010, the state enum, and the 4 KB boundary constant.
- No sub-module; the datapath is small. Share the beat counter and boundary check between the read and write paths.

Test Plan:
- Write addr=0x0010, len=3, data 0xA0..0xA3, slave OKAY -> AWADDR=0x0010, AWLEN=3, four W beats with WLAST only on 0xA3, done with resp 2'b00, done_err=0.
- Read addr=0x0100, len=0, slave returns 0xDEADBEEF RLAST=1 -> rd_data=0xDEADBEEF once, done resp 00.
- Read len=3, RRESP sequence 00,00,10,00 -> four rd beats, done_resp=2'b10.
- Write addr=0x0FF8, len=3 (crosses 4 KB) -> no AWVALID ever, done_err=1, done_resp=2'b10, 2 cycles after accept.
- Backpressure: AWREADY delayed 5 cycles, random WREADY/rd_ready gaps -> AW/AR signals and data stable while VALID && !READY, beat order preserved.
- ARESET pulsed in the middle of W beat 2 of len=7 -> all VALIDs low immediately, no done; next command completes normally.

Source files
------------

// File: rtl/axi4_pkg.sv
// axi4_pkg
// Shared definitions for the AXI4 burst master: response encodings, the
// fixed 4-byte beat size, the controller state enum and the 4 KB boundary
// helper used to reject bursts that would cross a page.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_4B = 3'b010;

  localparam logic [12:0] BOUNDARY_4K = 13'd4096;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    AW,
    W,
    B,
    AR,
    R,
    DONE
  } state_t;

  // True when a burst of (len+1) 4-byte beats starting at page offset offs
  // would run past the end of its 4 KB page. An end of exactly 4096 still
  // fits, so only strictly greater values are rejected.
  function automatic logic crosses4k(input logic [11:0] offs, input logic [7:0] len);
    logic [12:0] endAddr;
    endAddr = {1'b0, offs} + (({5'b0, len} + 13'd1) << 2);
    return endAddr > BOUNDARY_4K;
  endfunction

endpackage

// File: rtl/axi4_burst_master.sv
// axi4_burst_master
// Single-outstanding AXI4 initiator. Accepts one read or write burst command
// from a local client, issues it as INCR bursts of 32-bit beats on AW/W/B or
// AR/R, streams data straight through between client and bus, and ends every
// command with a one-cycle done pulse carrying the worst response seen.
//
// Ports:
//   ACLK, ARESET                     clock, async active-high reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write, cmd_addr, cmd_len     direction, byte address, beats-1
//   wr_data/wr_valid/wr_ready        client write beat stream
//   rd_data/rd_valid/rd_ready        client read beat stream
//   done, done_resp, done_err        completion pulse with response/error
//   AW*, W*, B*, AR*, R*             AXI4 manager channels
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_err,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            state;
  state_t            nextState;
  logic              isWrite;
  logic [ADDR_W-1:0] addrReg;
  logic [7:0]        lenReg;
  logic [8:0]        beat;
  logic [1:0]        respAcc;
  logic              errFlag;
  logic              lastBeat;
  logic              crossesBoundary;

  // The beat counter is 9 bits so a 256-beat burst reaches beat==255
  // without wrapping; it is shared by the read and write paths.
  assign lastBeat        = (beat == {1'b0, lenReg});
  assign crossesBoundary = crosses4k(addrReg[11:0], lenReg);

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and channel outputs. Address/len outputs are driven from the
  // latched command registers, so they stay stable for as long as VALID is
  // waiting on READY. Data channels are pure pass-through gated by state.
  always_comb begin
    nextState = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = RDATA;
    done      = 1'b0;
    done_resp = RESP_OKAY;
    done_err  = 1'b0;
    AWADDR    = addrReg;
    AWLEN     = lenReg;
    AWSIZE    = SIZE_4B;
    AWVALID   = 1'b0;
    WDATA     = wr_data;
    WLAST     = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARADDR    = addrReg;
    ARLEN     = lenReg;
    ARSIZE    = SIZE_4B;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = !ARESET;
        if (cmd_valid) nextState = CHECK;
      end
      CHECK: begin
        if (crossesBoundary) nextState = DONE;
        else if (isWrite)    nextState = AW;
        else                 nextState = AR;
      end
      AW: begin
        AWVALID = 1'b1;
        if (AWREADY) nextState = W;
      end
      W: begin
        WVALID   = wr_valid;
        wr_ready = WREADY;
        WLAST    = lastBeat;
        if (wr_valid && WREADY && lastBeat) nextState = B;
      end
      B: begin
        BREADY = 1'b1;
        if (BVALID) nextState = DONE;
      end
      AR: begin
        ARVALID = 1'b1;
        if (ARREADY) nextState = R;
      end
      R: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        if (RVALID && rd_ready && lastBeat) nextState = DONE;
      end
      DONE: begin
        done      = 1'b1;
        done_resp = respAcc;
        done_err  = errFlag;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Command latch, beat counting and response/error accumulation. A rejected
  // burst is reported as SLVERR with the error flag set. Reads keep the
  // numerically worst RRESP and flag any RLAST that disagrees with the count.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      isWrite <= 1'b0;
      addrReg <= '0;
      lenReg  <= '0;
      beat    <= '0;
      respAcc <= RESP_OKAY;
      errFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            isWrite <= cmd_write;
            addrReg <= cmd_addr & ALIGN_MASK;
            lenReg  <= cmd_len;
          end
        end
        CHECK: begin
          beat <= '0;
          if (crossesBoundary) begin
            respAcc <= RESP_SLVERR;
            errFlag <= 1'b1;
          end
        end
        W: begin
          if (wr_valid && WREADY) beat <= beat + 9'd1;
        end
        B: begin
          if (BVALID) respAcc <= BRESP;
        end
        R: begin
          if (RVALID && rd_ready) begin
            beat <= beat + 9'd1;
            if (RRESP > respAcc) respAcc <= RRESP;
            if (RLAST != lastBeat) errFlag <= 1'b1;
          end
        end
        DONE: begin
          respAcc <= RESP_OKAY;
          errFlag <= 1'b0;
          beat    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master
// Directed bench for axi4_burst_master. A reactive slave/client process
// drives the bus and client streams; a queue-based model built from the
// command (aligned address, beat list, worst response, boundary rule) is
// checked by a single compare process on every falling edge.
module tb_axi4_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic        done, done_err;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  axi4_burst_master #(.ADDR_W(16), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp), .done_err(done_err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model expectations
  typedef struct { logic [15:0] addr; logic [7:0] len; } addrT;
  typedef struct { logic [31:0] data; logic last; } wbT;
  typedef struct { logic [1:0] resp; logic err; } doneT;
  addrT        expAw[$];
  addrT        expAr[$];
  wbT          expW[$];
  logic [31:0] expRd[$];
  doneT        expDone[$];

  // Stimulus storage and slave/client configuration
  logic [31:0] wData [0:255];
  logic [31:0] rData [0:255];
  logic [1:0]  rResp [0:255];
  logic        rLast [0:255];
  int          wIdx = 0, wCount = 0, rIdx = 0, rCount = 0;
  int          awDelay = 0, awWait = 0, arWait = 0;
  bit          gapMode = 0, rArmed = 0;
  logic [1:0]  slvBresp = 2'b00;

  // Observations recorded by the compare process
  int          acceptCyc = 0, awRiseCyc = 0, awHsCyc = 0, arRiseCyc = 0, arHsCyc = 0, doneCyc = 0;
  int          doneCount = 0, awRises = 0, wBeats = 0, rdBeats = 0;
  logic [31:0] wLastData = '0, rdLastData = '0;
  logic [15:0] awSeenAddr = '0, arSeenAddr = '0;
  logic [1:0]  lastResp = '0;
  logic        lastErr = 1'b0;

  // Slave and client driver: samples handshakes on the falling edge, then
  // updates its outputs just after the following rising edge.
  initial begin
    bit awHs, arHs, wHs, rHs;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0;
    RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    forever begin
      @(negedge ACLK);
      awHs = AWVALID && AWREADY;
      arHs = ARVALID && ARREADY;
      wHs  = WVALID && WREADY;
      rHs  = RVALID && RREADY;
      @(posedge ACLK);
      #1;
      if (ARESET) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        wr_valid = 0; rd_ready = 0; rArmed = 0; awWait = 0; arWait = 0;
      end else begin
        if (wHs) wIdx++;
        if (rHs) rIdx++;
        if (arHs) begin rArmed = 1; rIdx = 0; end
        if (rArmed && rIdx >= rCount) rArmed = 0;
        if (AWVALID) begin AWREADY = (awWait >= awDelay); awWait++; end
        else begin AWREADY = 0; awWait = 0; end
        if (ARVALID) begin ARREADY = (arWait >= awDelay); arWait++; end
        else begin ARREADY = 0; arWait = 0; end
        wr_valid = (wIdx < wCount);
        wr_data  = wData[wIdx % 256];
        WREADY   = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
        BVALID   = BREADY;
        BRESP    = slvBresp;
        RVALID   = rArmed;
        RDATA    = rData[rIdx % 256];
        RRESP    = rResp[rIdx % 256];
        RLAST    = rLast[rIdx % 256];
        rd_ready = gapMode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Compare process: every falling edge, check visible outputs against the
  // head of the model queues and pop on handshakes.
  initial begin
    bit awHold = 0, arHold = 0, prevAwv = 0, prevArv = 0;
    addrT holdAw, holdAr;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        awHold = 0; arHold = 0; prevAwv = 0; prevArv = 0;
      end else begin
        if (cmd_valid && cmd_ready) acceptCyc = cyc;
        if (awHold) begin
          checkOutput("aw_valid_held", AWVALID, 1);
          checkOutput("aw_addr_held", AWADDR, holdAw.addr);
          checkOutput("aw_len_held", AWLEN, holdAw.len);
        end
        awHold = 0;
        if (AWVALID) begin
          if (!prevAwv) begin awRiseCyc = cyc; awRises++; end
          if (expAw.size() == 0) checkOutput("aw_unexpected", AWVALID, 0);
          else begin
            checkOutput("aw_addr", AWADDR, expAw[0].addr);
            checkOutput("aw_len", AWLEN, expAw[0].len);
            checkOutput("aw_size", AWSIZE, 3'b010);
            if (AWREADY) begin awSeenAddr = AWADDR; awHsCyc = cyc; void'(expAw.pop_front()); end
            else begin awHold = 1; holdAw.addr = AWADDR; holdAw.len = AWLEN; end
          end
        end
        prevAwv = AWVALID;
        if (arHold) begin
          checkOutput("ar_valid_held", ARVALID, 1);
          checkOutput("ar_addr_held", ARADDR, holdAr.addr);
          checkOutput("ar_len_held", ARLEN, holdAr.len);
        end
        arHold = 0;
        if (ARVALID) begin
          if (!prevArv) arRiseCyc = cyc;
          if (expAr.size() == 0) checkOutput("ar_unexpected", ARVALID, 0);
          else begin
            checkOutput("ar_addr", ARADDR, expAr[0].addr);
            checkOutput("ar_len", ARLEN, expAr[0].len);
            checkOutput("ar_size", ARSIZE, 3'b010);
            if (ARREADY) begin arSeenAddr = ARADDR; arHsCyc = cyc; void'(expAr.pop_front()); end
            else begin arHold = 1; holdAr.addr = ARADDR; holdAr.len = ARLEN; end
          end
        end
        prevArv = ARVALID;
        if (WVALID) begin
          checkOutput("w_before_aw", expAw.size(), 0);
          if (expW.size() == 0) checkOutput("w_unexpected", WVALID, 0);
          else begin
            checkOutput("w_data", WDATA, expW[0].data);
            checkOutput("w_last", WLAST, expW[0].last);
            checkOutput("wr_ready", wr_ready, WREADY);
            if (WREADY) begin
              if (WLAST) wLastData = WDATA;
              wBeats++;
              void'(expW.pop_front());
            end
          end
        end
        if (rd_valid) begin
          checkOutput("rready", RREADY, rd_ready);
          if (expRd.size() == 0) checkOutput("rd_unexpected", rd_valid, 0);
          else begin
            checkOutput("rd_data", rd_data, expRd[0]);
            if (rd_ready) begin rdLastData = rd_data; rdBeats++; void'(expRd.pop_front()); end
          end
        end
        if (done) begin
          if (expDone.size() == 0) checkOutput("done_unexpected", done, 0);
          else begin
            checkOutput("done_resp", done_resp, expDone[0].resp);
            checkOutput("done_err", done_err, expDone[0].err);
            void'(expDone.pop_front());
          end
          lastResp = done_resp; lastErr = done_err; doneCyc = cyc; doneCount++;
        end else begin
          checkOutput("idle_done_err", done_err, 0);
        end
      end
    end
  end

  task automatic flushModel();
    expAw.delete(); expAr.delete(); expW.delete(); expRd.delete(); expDone.delete();
  endtask

  // Build the expected traffic for one command, configure the slave/client,
  // and hand the command over. Called at posedge+2.
  task automatic applyStimulus(input logic isWr, input logic [15:0] addr, input logic [7:0] len,
                               input int dly, input bit gap, input logic [1:0] bresp);
    logic [15:0] aligned;
    int          endOffs;
    bit          reject;
    logic [1:0]  worst;
    bit          err;
    aligned = {addr[15:2], 2'b00};
    endOffs = int'(aligned[11:0]) + (int'(len) + 1) * 4;
    reject  = endOffs > 4096;
    if (reject) expDone.push_back('{2'b10, 1'b1});
    else if (isWr) begin
      expAw.push_back('{aligned, len});
      for (int i = 0; i <= int'(len); i++) expW.push_back('{wData[i], i == int'(len)});
      expDone.push_back('{bresp, 1'b0});
    end else begin
      expAr.push_back('{aligned, len});
      worst = 2'b00; err = 0;
      for (int i = 0; i <= int'(len); i++) begin
        expRd.push_back(rData[i]);
        if (rResp[i] > worst) worst = rResp[i];
        if (rLast[i] != (i == int'(len))) err = 1;
      end
      expDone.push_back('{worst, err});
    end
    wIdx = 0; wCount = (isWr && !reject) ? int'(len) + 1 : 0;
    rCount = int'(len) + 1; awDelay = dly; gapMode = gap; slvBresp = bresp;
    cmd_valid = 1; cmd_write = isWr; cmd_addr = addr; cmd_len = len;
    for (int k = 0; k < 50; k++) begin
      @(negedge ACLK);
      if (cmd_ready) break;
    end
    @(posedge ACLK);
    #2;
    cmd_valid = 0;
  endtask

  task automatic awaitDone(input int target);
    for (int k = 0; k < 3000; k++) begin
      if (doneCount >= target) break;
      @(negedge ACLK);
      #1;
    end
    checkOutput("done_count", doneCount, target);
    checkOutput("beats_left", expW.size() + expRd.size() + expDone.size(), 0);
    flushModel();
    @(posedge ACLK);
    #2;
  endtask

  initial begin
    int base;
    ARESET = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    for (int i = 0; i < 256; i++) begin rData[i] = 0; rResp[i] = 0; rLast[i] = 0; wData[i] = 0; end
    repeat (3) @(posedge ACLK);
    #2;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_awvalid", AWVALID, 0);
    checkOutput("rst_arvalid", ARVALID, 0);
    checkOutput("rst_wvalid", WVALID, 0);
    checkOutput("rst_bready", BREADY, 0);
    checkOutput("rst_rready", RREADY, 0);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_done_resp", done_resp, 0);
    checkOutput("rst_done_err", done_err, 0);
    ARESET = 0;
    @(posedge ACLK);
    #2;
    checkOutput("idle_cmd_ready", cmd_ready, 1);

    $display("[TB] write len=3 at 0x0010");
    for (int i = 0; i < 4; i++) wData[i] = 32'hA0 + i;
    applyStimulus(1, 16'h0010, 8'd3, 0, 0, 2'b00);
    awaitDone(1);
    checkOutput("t1_awaddr", awSeenAddr, 16'h0010);
    checkOutput("t1_latency", awRiseCyc - acceptCyc, 2);
    checkOutput("t1_beats", wBeats, 4);
    checkOutput("t1_last_data", wLastData, 32'hA3);
    checkOutput("t1_resp", lastResp, 2'b00);
    checkOutput("t1_err", lastErr, 0);

    $display("[TB] read len=0 at 0x0100");
    rData[0] = 32'hDEADBEEF; rResp[0] = 2'b00; rLast[0] = 1;
    base = rdBeats;
    applyStimulus(0, 16'h0100, 8'd0, 0, 0, 2'b00);
    awaitDone(2);
    checkOutput("t2_araddr", arSeenAddr, 16'h0100);
    checkOutput("t2_latency", arRiseCyc - acceptCyc, 2);
    checkOutput("t2_beats", rdBeats - base, 1);
    checkOutput("t2_data", rdLastData, 32'hDEADBEEF);
    checkOutput("t2_resp", lastResp, 2'b00);

    $display("[TB] read len=3 with SLVERR on beat 2");
    for (int i = 0; i < 4; i++) begin rData[i] = 32'h1000 + i; rResp[i] = 2'b00; rLast[i] = (i == 3); end
    rResp[2] = 2'b10;
    base = rdBeats;
    applyStimulus(0, 16'h0400, 8'd3, 0, 0, 2'b00);
    awaitDone(3);
    checkOutput("t3_beats", rdBeats - base, 4);
    checkOutput("t3_resp", lastResp, 2'b10);
    checkOutput("t3_err", lastErr, 0);

    $display("[TB] write crossing 4 KB is rejected");
    base = awRises;
    applyStimulus(1, 16'h0FF8, 8'd3, 0, 0, 2'b00);
    awaitDone(4);
    checkOutput("t4_no_aw", awRises - base, 0);
    checkOutput("t4_latency", doneCyc - acceptCyc, 2);
    checkOutput("t4_resp", lastResp, 2'b10);
    checkOutput("t4_err", lastErr, 1);

    $display("[TB] write ending exactly on 4 KB, unaligned address");
    for (int i = 0; i < 4; i++) wData[i] = 32'hC0DE0000 + i;
    applyStimulus(1, 16'h0FF3, 8'd3, 0, 0, 2'b01);
    awaitDone(5);
    checkOutput("t5_awaddr", awSeenAddr, 16'h0FF0);
    checkOutput("t5_resp", lastResp, 2'b01);

    $display("[TB] read with early RLAST, DECERR then EXOKAY");
    rData[0] = 32'h55; rResp[0] = 2'b11; rLast[0] = 1;
    rData[1] = 32'h66; rResp[1] = 2'b01; rLast[1] = 0;
    applyStimulus(0, 16'h0203, 8'd1, 0, 0, 2'b00);
    awaitDone(6);
    checkOutput("t6_araddr", arSeenAddr, 16'h0200);
    checkOutput("t6_resp", lastResp, 2'b11);
    checkOutput("t6_err", lastErr, 1);

    $display("[TB] backpressure write: AWREADY after 5 cycles, random WREADY");
    for (int i = 0; i < 6; i++) wData[i] = 32'h7700 + i * 3;
    applyStimulus(1, 16'h0200, 8'd5, 5, 1, 2'b00);
    awaitDone(7);
    checkOutput("t7_aw_wait", awHsCyc - awRiseCyc, 5);
    checkOutput("t7_last_data", wLastData, 32'h770F);

    $display("[TB] backpressure read: ARREADY after 3 cycles, random rd_ready");
    for (int i = 0; i < 5; i++) begin rData[i] = 32'h9900 + i; rResp[i] = 2'b00; rLast[i] = (i == 4); end
    base = rdBeats;
    applyStimulus(0, 16'h0300, 8'd4, 3, 1, 2'b00);
    awaitDone(8);
    checkOutput("t8_ar_wait", arHsCyc - arRiseCyc, 3);
    checkOutput("t8_beats", rdBeats - base, 5);
    checkOutput("t8_last_data", rdLastData, 32'h9904);

    $display("[TB] write len=255 up to the page end");
    for (int i = 0; i < 256; i++) wData[i] = i * 32'h01010101;
    base = wBeats;
    applyStimulus(1, 16'h0C00, 8'd255, 0, 0, 2'b00);
    awaitDone(9);
    checkOutput("t9_beats", wBeats - base, 256);
    checkOutput("t9_last_data", wLastData, 32'hFFFFFFFF);

    $display("[TB] reset during beat 2 of a len=7 write");
    for (int i = 0; i < 8; i++) wData[i] = 32'hB0 + i;
    base = wBeats;
    applyStimulus(1, 16'h0040, 8'd7, 0, 0, 2'b00);
    for (int k = 0; k < 100; k++) begin
      if (wBeats - base >= 2) break;
      @(negedge ACLK);
      #1;
    end
    checkOutput("t10_reached_beat2", wBeats - base, 2);
    @(posedge ACLK);
    #3;
    ARESET = 1;
    flushModel();
    wCount = 0;
    #1;
    checkOutput("t10_awvalid", AWVALID, 0);
    checkOutput("t10_wvalid", WVALID, 0);
    checkOutput("t10_wr_ready", wr_ready, 0);
    checkOutput("t10_bready", BREADY, 0);
    checkOutput("t10_done", done, 0);
    wr_valid = 0;
    repeat (2) @(posedge ACLK);
    #2;
    ARESET = 0;
    base = doneCount;
    repeat (6) @(posedge ACLK);
    #2;
    checkOutput("t10_no_done", doneCount - base, 0);
    wData[0] = 32'hE0; wData[1] = 32'hE1;
    applyStimulus(1, 16'h0080, 8'd1, 0, 0, 2'b00);
    awaitDone(base + 1);
    checkOutput("t10_after_addr", awSeenAddr, 16'h0080);
    checkOutput("t10_after_data", wLastData, 32'hE1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
